dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the word-addressed data memory. It lets two requesters share the memory's single read/write port: port 0 is the core load/store path and port 1 is a debug/DMA master. Each port uses a valid/ready request channel and a valid/ready response channel. The block drives the memory's read-enable, write-enable, address and write-data lines from registered state, so the memory never sees two requesters in the same cycle.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 17 +
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-port data-memory arbiter
package dmem_arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MEM_WORDS = 256;
  localparam int WIDX_MSB = $clog2(ARB_MEM_WORDS) + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic owner_t;
  typedef struct packed {
    owner_t owner;
    logic we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic err;
  } txn_t;
  function automatic int widx_msb(input int words);
    return $clog2(words) + 1;
  endfunction
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way request picker; round-robin on ptr under DMEM_ARB_RR_EN, else port 0 first
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  logic       ptr,
  output logic [1:0] gnt
);
`ifdef DMEM_ARB_RR_EN
  assign gnt = {v1 && (!v0 || ptr), v0 && (!v1 || !ptr)};
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign gnt = {v1 && !v0, v0};
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter and sequencer for a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int MEM_WORDS = ARB_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int MSB = widx_msb(MEM_WORDS);
  state_t state, state_nx;
  txn_t txn;
  logic [DATA_W-1:0] rdata;
  logic [1:0] gnt;
  logic ptr, hs, req_we, req_err, rsp_ack;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  dmem_arb_pick u_pick (.v0(m0_req_valid), .v1(m1_req_valid), .ptr(ptr), .gnt(gnt));
`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (hs) ptr <= ~gnt[1];
`else
  assign ptr = 1'b0;
`endif
  assign hs = state == IDLE && |gnt;
  assign req_we = gnt[1] ? m1_req_we : m0_req_we;
  assign req_addr = gnt[1] ? m1_req_addr : m0_req_addr;
  assign req_wdata = gnt[1] ? m1_req_wdata : m0_req_wdata;
  assign req_err = |req_addr[1:0] || |(req_addr >> (MSB + 1));
  assign rsp_ack = txn.owner ? m1_rsp_ready : m0_rsp_ready;
  assign mem_addr = ADDR_W'(txn.addr);
  assign mem_wdata = DATA_W'(txn.wdata);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      txn <= '0;
      rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state <= state_nx;
      mem_read <= hs && !req_we && !req_err;
      mem_write <= hs && req_we && !req_err;
      if (hs) txn <= '{owner: gnt[1], we: req_we, addr: ARB_ADDR_W'(req_addr),
                       wdata: ARB_DATA_W'(req_wdata), err: req_err};
      if (state == ACCESS) rdata <= (!txn.we && !txn.err) ? mem_rdata : '0;
    end
  always_comb begin
    state_nx = state == IDLE ? (hs ? ACCESS : IDLE) :
               state == ACCESS ? RESP : (rsp_ack ? IDLE : RESP);
    m0_req_ready = state == IDLE && gnt[0] && !rst;
    m1_req_ready = state == IDLE && gnt[1] && !rst;
    m0_rsp_valid = state == RESP && !txn.owner;
    m1_rsp_valid = state == RESP && txn.owner;
    m0_rsp_rdata = m0_rsp_valid ? rdata : '0;
    m1_rsp_rdata = m1_rsp_valid ? rdata : '0;
    m0_rsp_err = m0_rsp_valid && txn.err;
    m1_rsp_err = m1_rsp_valid && txn.err;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk, rst;
  logic m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata, m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  bit ptr_m;
  bit pend [2];
  logic we_r [2];
  logic [31:0] addr_r [2], wdata_r [2];
  logic [31:0] last_d, exp_bp;
  logic last_e;
  int n_chk, n_fail;
  typedef struct { int p; bit we; logic [31:0] addr, wdata, ed; bit ee; } vec_t;
  vec_t tbl [8];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory environment: reloads its image whenever reset is held over a clock edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (rst) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  function automatic bit m_err(input logic [31:0] a);
    return (a % 4) != 0 || a >= 32'd1024;
  endfunction
  function automatic logic rdy(input int p);
    return p == 1 ? m1_req_ready : m0_req_ready;
  endfunction
  function automatic logic rspv(input int p);
    return p == 1 ? m1_rsp_valid : m0_rsp_valid;
  endfunction
  function automatic logic [31:0] rspd(input int p);
    return p == 1 ? m1_rsp_rdata : m0_rsp_rdata;
  endfunction
  function automatic logic rspe(input int p);
    return p == 1 ? m1_rsp_err : m0_rsp_err;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    ptr_m = 1'b0;
  endtask
  task automatic drive();
    m0_req_valid = pend[0]; m0_req_we = we_r[0]; m0_req_addr = addr_r[0]; m0_req_wdata = wdata_r[0];
    m1_req_valid = pend[1]; m1_req_we = we_r[1]; m1_req_addr = addr_r[1]; m1_req_wdata = wdata_r[1];
  endtask
  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    pend[p] = 1'b1; we_r[p] = we; addr_r[p] = a; wdata_r[p] = d;
  endtask

  // Services every pending request, checking grant order and per-cycle timing against the model
  task automatic serve();
    int w;
    bit e;
    logic [31:0] ed;
    step();
    drive();
    while (pend[0] || pend[1]) begin
      #1;
      w = (pend[0] && pend[1]) ? (RR ? int'(ptr_m) : 0) : (pend[1] ? 1 : 0);
      chk("grant_ready", rdy(w), 1);
      chk("loser_ready", rdy(1 - w), 0);
      e = m_err(addr_r[w]);
      ed = (!we_r[w] && !e) ? shadow[addr_r[w][9:2]] : 32'h0;
      if (we_r[w] && !e) shadow[addr_r[w][9:2]] = wdata_r[w];
      ptr_m = (w == 0);
      step();
      pend[w] = 1'b0;
      drive();
      #1;
      chk("mem_read", mem_read, !we_r[w] && !e);
      chk("mem_write", mem_write, we_r[w] && !e);
      if (!e) chk("mem_addr", mem_addr, addr_r[w]);
      if (!e && we_r[w]) chk("mem_wdata", mem_wdata, wdata_r[w]);
      chk("ready_in_access", m0_req_ready | m1_req_ready, 0);
      step();
      #1;
      chk("rsp_valid", rspv(w), 1);
      chk("rsp_valid_other", rspv(1 - w), 0);
      chk("rsp_rdata", rspd(w), ed);
      chk("rsp_err", rspe(w), e);
      chk("ready_in_resp", m0_req_ready | m1_req_ready, 0);
      last_d = rspd(w);
      last_e = rspe(w);
      step();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    pend[0] = 0; pend[1] = 0; we_r[0] = 0; we_r[1] = 0;
    addr_r[0] = 0; addr_r[1] = 0; wdata_r[0] = 0; wdata_r[1] = 0;
    drive();
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    model_reset();
    tbl[0] = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
    tbl[1] = '{1, 1, 32'h3FC, 32'h12345678, 32'h0, 0};
    tbl[2] = '{1, 0, 32'h3FC, 32'h0, 32'h12345678, 0};
    tbl[3] = '{0, 1, 32'h6, 32'h55AA55AA, 32'h0, 1};
    tbl[4] = '{0, 1, 32'h400, 32'h55AA55AA, 32'h0, 1};
    tbl[5] = '{0, 0, 32'h400, 32'h0, 32'h0, 1};
    tbl[6] = '{1, 0, 32'h8000_0010, 32'h0, 32'h0, 1};
    tbl[7] = '{0, 0, 32'h0, 32'h0, 32'h1000_0000, 0};
    repeat (3) @(posedge clk);
    #1;
    m0_req_valid = 1'b1;
    #1;
    chk("rst_m0_ready", m0_req_ready, 0);
    chk("rst_m1_ready", m1_req_ready, 0);
    chk("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    chk("rst_rsp_data", m0_rsp_rdata | m1_rsp_rdata, 0);
    chk("rst_mem_en", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    m0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      serve();
      chk("tbl_rdata", last_d, tbl[i].ed);
      chk("tbl_err", last_e, tbl[i].ee);
    end

    // Contention from a fresh reset, then a lone m0 grant followed by contention
    step(); rst = 1'b1; step(); rst = 1'b0; model_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(0, 0, 32'h10 + 32'(i) * 8, 0);
      set_req(1, 0, 32'h20 + 32'(i) * 8, 0);
      serve();
    end
    set_req(0, 0, 32'h40, 0);
    serve();
    set_req(0, 0, 32'h44, 0);
    set_req(1, 0, 32'h48, 0);
    serve();

    // Response back-pressure on m0 while m1 waits
    step();
    set_req(0, 0, 32'h10, 0);
    drive();
    m0_rsp_ready = 1'b0;
    #1;
    chk("bp_m0_ready", m0_req_ready, 1);
    exp_bp = shadow[4];
    ptr_m = 1'b1;
    step();
    pend[0] = 1'b0;
    set_req(1, 0, 32'h20, 0);
    drive();
    #1;
    chk("bp_m1_ready_access", m1_req_ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", m0_rsp_valid, 1);
      chk("bp_rsp_rdata", m0_rsp_rdata, exp_bp);
      chk("bp_rsp_err", m0_rsp_err, 0);
      chk("bp_m1_ready", m1_req_ready, 0);
      chk("bp_m1_rsp_valid", m1_rsp_valid, 0);
      step();
    end
    m0_rsp_ready = 1'b1;
    #1;
    chk("bp_no_comb_path", m1_req_ready, 0);
    step();
    chk("bp_m1_grant_next", m1_req_ready, 1);
    ptr_m = 1'b0;
    step();
    pend[1] = 1'b0;
    drive();
    step();
    chk("bp_m1_rsp_valid_end", m1_rsp_valid, 1);
    chk("bp_m1_rsp_rdata", m1_rsp_rdata, shadow[8]);
    step();

    // Reset while a write is in ACCESS
    set_req(0, 1, 32'h40, 32'hCAFEF00D);
    drive();
    #1;
    chk("mid_ready", m0_req_ready, 1);
    step();
    pend[0] = 1'b0;
    drive();
    chk("mid_mem_write", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("mid_mem_en", {mem_read, mem_write}, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_mem_wdata", mem_wdata, 0);
    chk("mid_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    chk("mid_ready_rst", {m0_req_ready, m1_req_ready}, 0);
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
      step();
    end
    set_req(0, 0, 32'h40, 0);
    serve();
    chk("mid_after_read", last_d, init_word(16));

    for (int i = 0; i < 40; i++) begin
      int v, k;
      v = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        k = $urandom_range(0, 9);
        pend[p] = v[p];
        we_r[p] = 1'($urandom_range(0, 1));
        wdata_r[p] = $urandom;
        addr_r[p] = k == 0 ? 32'($urandom_range(0, 1023)) : k == 1 ? $urandom :
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      serve();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
